// File: rtl/energy_ratio_calc_pkg.sv
`default_nettype none
// =============================================================================
// Module      : energy_ratio_calc_pkg
// Description : Constants shared by the energy ratio calculator and the matcher.
// Revision    : 1.0 - initial release
// =============================================================================
package energy_ratio_calc_pkg;

    localparam int RATIO_W    = 10;
    localparam int RATIO_MAX  = 1023;
    localparam int DIV_STAGES = 10;
    // The matcher's pulse-width offset; both blocks must agree on it.
    localparam int ENERGY_WIN = 64;

endpackage
`default_nettype wire

// File: rtl/ratio_div_pipe.sv
`default_nettype none
// =============================================================================
// Module      : ratio_div_pipe
// Description : Saturation stage plus 10-stage restoring divider, q = floor(N/D).
// Revision    : 1.0 - initial release
// =============================================================================
module ratio_div_pipe
    import energy_ratio_calc_pkg::*;
#(
    parameter int WIDTH = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_num,
    input  logic [WIDTH-1:0]   i_den,
    output logic [RATIO_W-1:0] o_quot,
    output logic               o_valid
);

    localparam int c_XW = WIDTH + RATIO_W;

    logic [DIV_STAGES-1:0] r_v;
    logic [WIDTH-1:0]      r_rem  [DIV_STAGES];
    logic [WIDTH-1:0]      r_den  [DIV_STAGES];
    logic [RATIO_W-1:0]    r_q    [DIV_STAGES];

    logic [c_XW-1:0]       w_sub  [DIV_STAGES];
    logic [WIDTH-1:0]      w_diff [DIV_STAGES];
    logic [DIV_STAGES-1:0] w_ge;
    logic [c_XW-1:0]       w_den_big;
    logic                  w_num_zero;
    logic                  w_sat;

    always_comb begin
        w_den_big  = {{RATIO_W{1'b0}}, i_den} << RATIO_W;
        w_num_zero = (i_num == '0);
        w_sat      = (i_den == '0) || ({{RATIO_W{1'b0}}, i_num} >= w_den_big);
        for (int k = 0; k < DIV_STAGES; k++) begin
            w_sub[k]  = {{RATIO_W{1'b0}}, r_den[k]} << (DIV_STAGES - 1 - k);
            w_ge[k]   = ({{RATIO_W{1'b0}}, r_rem[k]} >= w_sub[k]);
            w_diff[k] = r_rem[k] - w_sub[k][WIDTH-1:0];
        end
    end

    // Forced results enter with rem=0, den=1 so no stage ever subtracts
    // and the preloaded quotient passes through untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v     <= '0;
            o_valid <= 1'b0;
            o_quot  <= '0;
            for (int k = 0; k < DIV_STAGES; k++) begin
                r_rem[k] <= '0;
                r_den[k] <= '0;
                r_q[k]   <= '0;
            end
        end else begin
            r_v[0] <= i_valid;
            if (w_num_zero) begin
                r_rem[0] <= '0;
                r_den[0] <= WIDTH'(1);
                r_q[0]   <= '0;
            end else if (w_sat) begin
                r_rem[0] <= '0;
                r_den[0] <= WIDTH'(1);
                r_q[0]   <= RATIO_W'(RATIO_MAX);
            end else begin
                r_rem[0] <= i_num;
                r_den[0] <= i_den;
                r_q[0]   <= '0;
            end
            for (int k = 0; k < DIV_STAGES - 1; k++) begin
                r_v[k+1]   <= r_v[k];
                r_rem[k+1] <= w_ge[k] ? w_diff[k] : r_rem[k];
                r_den[k+1] <= r_den[k];
                r_q[k+1]   <= r_q[k] | (RATIO_W'(w_ge[k]) << (DIV_STAGES - 1 - k));
            end
            o_valid <= r_v[DIV_STAGES-1];
            if (r_v[DIV_STAGES-1]) begin
                o_quot <= r_q[DIV_STAGES-1] | RATIO_W'(w_ge[DIV_STAGES-1]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/energy_ratio_calc.sv
`default_nettype none
// =============================================================================
// Module      : energy_ratio_calc
// Description : Sliding FRONT/BACK energy windows and their saturated ratios.
// Revision    : 1.0 - initial release
// =============================================================================
module energy_ratio_calc
    import energy_ratio_calc_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int WIN    = ENERGY_WIN
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] din,
    input  logic                     din_valid,
    output logic [RATIO_W-1:0]       fb_ratio,
    output logic [RATIO_W-1:0]       bf_ratio,
    output logic                     ratio_valid,
    output logic                     primed
);

    localparam int c_E_W    = 2 * DATA_W;
    localparam int c_S_W    = c_E_W + $clog2(WIN);
    localparam int c_DEPTH  = 2 * WIN;
    localparam int c_PTR_W  = $clog2(c_DEPTH);
    localparam int c_FILL_W = c_PTR_W + 1;

    logic signed [c_E_W-1:0] w_din_ext;
    logic [c_E_W-1:0]        w_sq;
    logic [c_E_W-1:0]        w_e_mid;
    logic [c_E_W-1:0]        w_e_old;
    logic [c_PTR_W-1:0]      w_mid_ptr;
    logic                    w_fb_valid;
    logic                    w_bf_valid;

    logic [c_E_W-1:0]        r_e;
    logic                    r_v1;
    logic                    r_v2;
    logic [c_PTR_W-1:0]      r_ptr;
    logic [c_FILL_W-1:0]     r_fill;
    logic [c_S_W-1:0]        r_front;
    logic [c_S_W-1:0]        r_back;
    logic [c_E_W-1:0]        r_mem [c_DEPTH];

    assign w_din_ext = c_E_W'(din);
    assign w_sq      = w_din_ext * w_din_ext;
    assign w_mid_ptr = r_ptr - c_PTR_W'(WIN);

    // The buffer is never cleared; the fill count masks stale entries so the
    // sums start exact after every reset.
    assign w_e_mid = (r_fill >= c_FILL_W'(WIN)) ? r_mem[w_mid_ptr] : '0;
    assign w_e_old = r_fill[c_FILL_W-1] ? r_mem[r_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_e     <= '0;
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_ptr   <= '0;
            r_fill  <= '0;
            r_front <= '0;
            r_back  <= '0;
        end else begin
            r_v1 <= din_valid;
            if (din_valid) begin
                r_e <= w_sq;
            end
            r_v2 <= r_v1 && (r_fill >= c_FILL_W'(c_DEPTH - 1));
            if (r_v1) begin
                r_front <= r_front + c_S_W'(r_e) - c_S_W'(w_e_mid);
                r_back  <= r_back + c_S_W'(w_e_mid) - c_S_W'(w_e_old);
                r_ptr   <= r_ptr + c_PTR_W'(1);
                if (!r_fill[c_FILL_W-1]) begin
                    r_fill <= r_fill + c_FILL_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_v1) begin
            r_mem[r_ptr] <= r_e;
        end
    end

    // Fill saturates at 2*WIN, a power of two, so its MSB is the primed flag.
    assign primed = r_fill[c_FILL_W-1];

    ratio_div_pipe #(.WIDTH(c_S_W)) u_div_fb (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_v2),
        .i_num   (r_front),
        .i_den   (r_back),
        .o_quot  (fb_ratio),
        .o_valid (w_fb_valid)
    );

    ratio_div_pipe #(.WIDTH(c_S_W)) u_div_bf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (r_v2),
        .i_num   (r_back),
        .i_den   (r_front),
        .o_quot  (bf_ratio),
        .o_valid (w_bf_valid)
    );

    assign ratio_valid = w_fb_valid & w_bf_valid;

endmodule
`default_nettype wire

// File: tb/tb_energy_ratio_calc.sv
`default_nettype none
// =============================================================================
// Module      : tb_energy_ratio_calc
// Description : Self-checking bench for energy_ratio_calc against a window-sum model.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_energy_ratio_calc;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [11:0] din;
    logic              din_valid;
    logic [9:0]        fb_ratio;
    logic [9:0]        bf_ratio;
    logic              ratio_valid;
    logic              primed;

    typedef struct {
        int     fb;
        int     bf;
        longint due;
    } exp_t;

    exp_t   exp_q[$];
    longint hist[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     amps[5] = '{2047, 300, 20, 1, 0};

    energy_ratio_calc #(.DATA_W(12), .WIN(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .fb_ratio    (fb_ratio),
        .bf_ratio    (bf_ratio),
        .ratio_valid (ratio_valid),
        .primed      (primed)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int ref_ratio(input longint n, input longint d);
        if (n == 0) return 0;
        if (d == 0) return 1023;
        if (n / d > 1023) return 1023;
        return int'(n / d);
    endfunction

    // Keep the last 128 energies; FRONT is the newest 64, BACK the 64 before.
    task automatic model_push(input int s);
        longint e;
        longint front;
        longint back;
        exp_t   x;
        e = longint'(s) * longint'(s);
        hist.push_back(e);
        if (hist.size() > 128) void'(hist.pop_front());
        if (hist.size() == 128) begin
            front = 0;
            back  = 0;
            for (int i = 0; i < 64; i++) back += hist[i];
            for (int i = 64; i < 128; i++) front += hist[i];
            x.fb  = ref_ratio(front, back);
            x.bf  = ref_ratio(back, front);
            x.due = cyc + 13;
            exp_q.push_back(x);
        end
    endtask

    task automatic step(input bit v, input int s);
        @(negedge clk);
        din       = s[11:0];
        din_valid = v;
        if (v) model_push(s);
    endtask

    task automatic drain();
        @(negedge clk);
        din_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        hist.delete();
        exp_q.delete();
        #1;
        chk("rst_fb", fb_ratio, 0);
        chk("rst_bf", bf_ratio, 0);
        chk("rst_valid", ratio_valid, 0);
        chk("rst_primed", primed, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_step_change(input int gap);
        for (int i = 0; i < 128; i++) begin
            step(1, 1);
            repeat (gap) step(0, 0);
        end
        for (int i = 0; i < 64; i++) begin
            step(1, 10);
            repeat (gap) step(0, 0);
        end
        drain();
        chk("step_fb", fb_ratio, 100);
        chk("step_bf", bf_ratio, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && ratio_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ratio_valid", ratio_valid, 0);
            end else begin
                e = exp_q.pop_front();
                chk("fb_ratio", fb_ratio, e.fb);
                chk("bf_ratio", bf_ratio, e.bf);
                chk("latency_cycle", 32'(cyc), 32'(e.due));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int amp;
        int s;
        rst_n     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("init_fb", fb_ratio, 0);
        chk("init_bf", bf_ratio, 0);
        chk("init_valid", ratio_valid, 0);
        chk("init_primed", primed, 0);
        rst_n = 1'b1;

        // Constant input: priming boundary and unity ratios.
        for (int i = 0; i < 127; i++) step(1, 10);
        repeat (3) step(0, 0);
        chk("primed_at_127", primed, 0);
        step(1, 10);
        repeat (3) step(0, 0);
        chk("primed_at_128", primed, 1);
        for (int i = 0; i < 40; i++) step(1, 10);
        drain();
        chk("const_fb", fb_ratio, 1);
        chk("const_bf", bf_ratio, 1);

        // Reset with results in flight, then 127 samples never prime.
        for (int i = 0; i < 20; i++) step(1, 10);
        do_reset();
        for (int i = 0; i < 127; i++) step(1, int'($urandom_range(0, 4094)) - 2047);
        repeat (15) step(0, 0);
        chk("unprimed_127", primed, 0);

        do_reset();
        run_step_change(0);

        do_reset();
        for (int i = 0; i < 128; i++) step(1, 0);
        drain();
        chk("zero_fb", fb_ratio, 0);
        chk("zero_bf", bf_ratio, 0);
        step(1, 5);
        drain();
        chk("impulse_fb", fb_ratio, 1023);
        chk("impulse_bf", bf_ratio, 0);

        do_reset();
        for (int i = 0; i < 136; i++) step(1, -2048);
        drain();
        chk("fullscale_fb", fb_ratio, 1);
        chk("fullscale_bf", bf_ratio, 1);
        for (int i = 0; i < 64; i++) step(1, 0);
        drain();
        chk("silence_fb", fb_ratio, 0);
        chk("silence_bf", bf_ratio, 1023);

        do_reset();
        run_step_change(2);

        // Random amplitude blocks with random gaps.
        do_reset();
        for (int b = 0; b < 12; b++) begin
            amp = amps[$urandom_range(0, 4)];
            for (int i = 0; i < 60; i++) begin
                s = int'($urandom_range(0, 2 * amp)) - amp;
                if (amp == 2047 && $urandom_range(0, 7) == 0) s = -2048;
                step($urandom_range(0, 3) != 0, s);
            end
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
